lms7_tx_brst_gate: RTL and testbench
====================================

// Module: lms7_tx_brst_gate
// PURPOSE
// - Timestamp-gated TX burst gate sitting directly upstream of the LMS7 TX framer; drives its 48-bit sample FIFO interface.
// - Accepts 64-bit host words (4x16-bit samples) and reduces each sample to 12 bits.
// - Holds each burst until the sample timestamp reaches the requested start time, then streams exactly burst_len words.
// - Flags late bursts (dropped) and underruns (framer requested a sample mid-burst, none available).
// PARAMETERS
// - TS_WIDTH   32  width of timestamps (burst_ts, ts_now)
// - LEN_WIDTH  16  width of burst length in 64-bit words
// PORTS
// - mclk             in   1          sample clock, shared with the TX framer
// - rst_n            in   1          asynchronous active-low reset
// - abort            in   1          sync abort: cancel current burst
// - cmd_valid        in   1          burst command valid
// - cmd_ready        out  1          command accepted when cmd_valid && cmd_ready
// - cmd_ts           in   TS_WIDTH   burst start timestamp
// - cmd_len          in   LEN_WIDTH  burst length in words; 0 = empty burst
// - ts_now           in   TS_WIDTH   current TX sample timestamp
// - s_tdata          in   64         {aq,bq,ai,bi} 16-bit each, bi at [15:0]
// - s_tvalid         in   1          host word valid
// - s_tready         out  1          host word accepted
// - m_tdata          out  48         {aq,bq,ai,bi} 12-bit each, bi at [11:0]
// - m_tvalid         out  1          sample word valid to framer
// - m_tready         in   1          framer sample release
// - busy             out  1          state != IDLE
// - burst_done       out  1          1-cycle pulse: burst fully delivered
// - late             out  1          1-cycle pulse: burst start already passed, burst dropped
// - underrun         out  1          1-cycle pulse: m_tready && !m_tvalid in STREAM
// - underrun_cnt     out  16         saturating underrun counter, cleared on cmd accept
// BEHAVIOUR
// - Reset: state=IDLE; m_tdata=0; m_tvalid, s_tready, burst_done, late, underrun=0; underrun_cnt=0; cmd_ready=1.
// - cmd_ready = (state==IDLE) && !abort. Accept latches cmd_ts, cmd_len; clears word counter and underrun_cnt.
// - IDLE -> WAIT_TS on accept with cmd_len!=0; with cmd_len==0 stays IDLE, burst_done pulses next cycle.
// - WAIT_TS: d = ts_now - cmd_ts (mod 2^TS_WIDTH, signed).
//   - d==0 -> STREAM.
//   - d>0 (MSB 0, nonzero) on first WAIT_TS cycle -> late pulse, -> DROP.
//   - d<0 -> wait.
// - STREAM: s_tready = (cnt<len) && (!m_tvalid || m_tready).
//   - Each s handshake loads m_tdata, sets m_tvalid, cnt++.
//   - m_tvalid clears on m_tready when no new load; latency s->m is 1 cycle.
//   - cnt==len -> DRAIN.
// - DRAIN: s_tready=0; when m_tvalid==0 or (m_tvalid && m_tready) -> IDLE with burst_done pulse.
// - DROP: s_tready=1, m_tvalid=0; consume len words; last consume -> IDLE (no burst_done).
// - Underrun: STREAM && m_tready && !m_tvalid -> underrun pulse; underrun_cnt++, holds at 0xFFFF. Not flagged in WAIT_TS/DRAIN/IDLE.
// - Reduction: out12 = in16[15:4] (truncate toward -inf), per lane, same lane order.
// - abort (any state): next cycle state=IDLE, m_tvalid=0, s_tready=0, no done/late. Pending host data is not consumed.
// - abort with cmd_valid in same cycle: abort wins, no accept.
// - cmd_len counter compares LEN_WIDTH-wide; max burst 2^LEN_WIDTH-1 words.
// - Async reset mid-burst returns to reset values immediately; partial burst is lost.
// CONFIGURATION
// - LMS7_TX_BRST_ROUND_EN defined: out12 = sat12((in16 + 8) >>> 4).
//   - Round half up; 0x7FF8..0x7FFF saturate to 0x7FF; never wraps negative.
// - LMS7_TX_BRST_ROUND_EN undefined: plain truncation in16[15:4], no adder in path.
// - Handshake and latency are identical in both builds.
// TESTING
// - Basic: cmd_ts=100, cmd_len=4, ts_now counts from 90, words always valid, m_tready=1 -> first m_tvalid at ts_now=101; 4 words; burst_done 1 cycle after last.
// - Data map: s_tdata=0x7FF0_8000_1234_FFFF -> m_tdata=0x7FF_800_123_FFF (truncate); ROUND_EN build -> 0x7FF_800_123_000.
// - Late: cmd_ts=50 accepted while ts_now=60, cmd_len=3 -> late pulse; 3 words consumed; m_tvalid stays 0; no burst_done.
// - Underrun: STREAM, m_tready every 2nd cycle, s_tvalid low for 3 release slots -> underrun_cnt=3, burst still completes with all words.
// - Backpressure: m_tready low 5 cycles mid-burst -> m_tdata stable, no word lost or duplicated (scoreboard).
// - Abort/edge: abort in STREAM after 2 of 8 words -> IDLE next cycle, m_tvalid=0. Then cmd_len=0 -> burst_done, busy never set.
// - Wrap: cmd_ts=0x0000_0002 with ts_now=0xFFFF_FFFE -> waits 4 cycles, then STREAM, not late.

Source files
------------

// File: rtl/lms7_tx_brst_gate.sv
// Timestamp-gated TX burst gate feeding the LMS7 framer sample FIFO.
// Define LMS7_TX_BRST_ROUND_EN for round-half-up 16->12 bit reduction.
module lms7_tx_brst_gate #(
    parameter int TS_WIDTH  = 32,
    parameter int LEN_WIDTH = 16
) (
    input  logic                 mclk,
    input  logic                 rst_n,
    input  logic                 abort,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [TS_WIDTH-1:0]  cmd_ts,
    input  logic [LEN_WIDTH-1:0] cmd_len,
    input  logic [TS_WIDTH-1:0]  ts_now,
    input  logic [63:0]          s_tdata,
    input  logic                 s_tvalid,
    output logic                 s_tready,
    output logic [47:0]          m_tdata,
    output logic                 m_tvalid,
    input  logic                 m_tready,
    output logic                 busy,
    output logic                 burst_done,
    output logic                 late,
    output logic                 underrun,
    output logic [15:0]          underrun_cnt
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WAIT   = 3'd1;
    localparam logic [2:0] S_STREAM = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_DROP   = 3'd4;

    logic [2:0]           state_q, state_d;
    logic [TS_WIDTH-1:0]  ts_q, ts_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
    logic                 first_q, first_d;
    logic [47:0]          m_tdata_q, m_tdata_d;
    logic                 m_tvalid_q, m_tvalid_d;
    logic                 done_q, done_d;
    logic                 late_q, late_d;
    logic                 und_q, und_d;
    logic [15:0]          ucnt_q, ucnt_d;

    logic [TS_WIDTH-1:0]  d;
    logic                 d_zero;
    logic                 d_pos;
    logic                 stream_go;
    logic                 s_hs;
    logic [LEN_WIDTH-1:0] cnt_inc;
    logic [47:0]          red_data;

    assign d       = ts_now - ts_q;
    assign d_zero  = (d == '0);
    assign d_pos   = !d[TS_WIDTH-1] && !d_zero;
    assign cnt_inc = cnt_q + LEN_WIDTH'(1);

`ifdef LMS7_TX_BRST_ROUND_EN
    logic [3:0][16:0] rsum;
    logic             unused_rsum;

    always_comb begin
        rsum     = '0;
        red_data = '0;
        for (int l = 0; l < 4; l++) begin
            rsum[l] = {s_tdata[l*16+15], s_tdata[l*16 +: 16]} + 17'd8;
            // positive overflow past 0x7FFF clamps instead of wrapping
            red_data[l*12 +: 12] = (!rsum[l][16] && rsum[l][15]) ?
                                   12'h7FF : rsum[l][15:4];
        end
    end

    assign unused_rsum = ^{rsum[0][3:0], rsum[1][3:0],
                           rsum[2][3:0], rsum[3][3:0]};
`else
    logic unused_lo;

    always_comb begin
        red_data = '0;
        for (int l = 0; l < 4; l++) begin
            red_data[l*12 +: 12] = s_tdata[l*16+4 +: 12];
        end
    end

    assign unused_lo = ^{s_tdata[51:48], s_tdata[35:32],
                         s_tdata[19:16], s_tdata[3:0]};
`endif

    // the cycle ts_now hits the start time already takes the first word
    assign stream_go = (state_q == S_STREAM) ||
                       ((state_q == S_WAIT) && d_zero);

    assign s_tready = !abort &&
                      ((stream_go && (cnt_q < len_q) &&
                        (!m_tvalid_q || m_tready)) ||
                       (state_q == S_DROP));
    assign s_hs      = s_tvalid && s_tready;
    assign cmd_ready = (state_q == S_IDLE) && !abort;

    always_comb begin
        state_d    = state_q;
        ts_d       = ts_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        first_d    = first_q;
        m_tdata_d  = m_tdata_q;
        m_tvalid_d = m_tvalid_q;
        done_d     = 1'b0;
        late_d     = 1'b0;
        und_d      = 1'b0;
        ucnt_d     = ucnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    ts_d    = cmd_ts;
                    len_d   = cmd_len;
                    cnt_d   = '0;
                    ucnt_d  = '0;
                    first_d = 1'b1;
                    if (cmd_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                first_d = 1'b0;
                if (d_zero) begin
                    state_d = S_STREAM;
                end else if (d_pos) begin
                    if (first_q) begin
                        late_d  = 1'b1;
                        state_d = S_DROP;
                    end else begin
                        state_d = S_STREAM;
                    end
                end
            end
            S_STREAM: begin
                if (m_tready && !m_tvalid_q) begin
                    und_d = 1'b1;
                    if (ucnt_q != 16'hFFFF) begin
                        ucnt_d = ucnt_q + 16'd1;
                    end
                end
            end
            S_DRAIN: begin
                if (!m_tvalid_q || m_tready) begin
                    m_tvalid_d = 1'b0;
                    done_d     = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            S_DROP: begin
                m_tvalid_d = 1'b0;
                if (s_hs) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == len_q) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (stream_go) begin
            if (s_hs) begin
                m_tdata_d  = red_data;
                m_tvalid_d = 1'b1;
                cnt_d      = cnt_inc;
            end else if (m_tready) begin
                m_tvalid_d = 1'b0;
            end
            if (cnt_d == len_q) begin
                state_d = S_DRAIN;
            end
        end

        if (abort) begin
            state_d    = S_IDLE;
            m_tvalid_d = 1'b0;
            done_d     = 1'b0;
            late_d     = 1'b0;
            und_d      = 1'b0;
            ucnt_d     = ucnt_q;
        end
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            ts_q       <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            first_q    <= 1'b0;
            m_tdata_q  <= '0;
            m_tvalid_q <= 1'b0;
            done_q     <= 1'b0;
            late_q     <= 1'b0;
            und_q      <= 1'b0;
            ucnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            ts_q       <= ts_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            first_q    <= first_d;
            m_tdata_q  <= m_tdata_d;
            m_tvalid_q <= m_tvalid_d;
            done_q     <= done_d;
            late_q     <= late_d;
            und_q      <= und_d;
            ucnt_q     <= ucnt_d;
        end
    end

    assign m_tdata      = m_tdata_q;
    assign m_tvalid     = m_tvalid_q;
    assign busy         = (state_q != S_IDLE);
    assign burst_done   = done_q;
    assign late         = late_q;
    assign underrun     = und_q;
    assign underrun_cnt = ucnt_q;

endmodule

// File: tb/tb_lms7_tx_brst_gate.sv
// Directed bench for lms7_tx_brst_gate: start gating, data map,
// late drop, underrun, zero-length, backpressure, abort, ts wrap.
`timescale 1ns/1ps
module tb_lms7_tx_brst_gate;

    logic        mclk;
    logic        rst_n;
    logic        abort;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_ts;
    logic [15:0] cmd_len;
    logic [31:0] ts_now;
    logic [63:0] s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic [47:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        busy;
    logic        burst_done;
    logic        late;
    logic        underrun;
    logic [15:0] underrun_cnt;

    lms7_tx_brst_gate dut (
        .mclk(mclk), .rst_n(rst_n), .abort(abort),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_ts(cmd_ts), .cmd_len(cmd_len), .ts_now(ts_now),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .busy(busy), .burst_done(burst_done), .late(late),
        .underrun(underrun), .underrun_cnt(underrun_cnt)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    int n_vec = 0;
    int n_err = 0;
    int n_done = 0, n_late = 0, n_und = 0;
    int n_mv = 0, n_out = 0, n_cons = 0;
    int sidx = 0;
    logic        seen_mv;
    logic [31:0] mv_ts, done_ts;
    logic        drop_mode, fix_mode;
    logic [63:0] fw [2];
    logic [47:0] mq [$];
    logic [47:0] outq [$];

`ifdef LMS7_TX_BRST_ROUND_EN
    localparam logic [47:0] EXP0 = 48'h7FF_800_123_000;
    localparam logic [47:0] EXP1 = 48'h7FF_7FF_001_000;
`else
    localparam logic [47:0] EXP0 = 48'h7FF_800_123_FFF;
    localparam logic [47:0] EXP1 = 48'h7FF_7FF_000_FFF;
`endif

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [47:0] red_m(input logic [63:0] w);
        logic [47:0] r;
        int v;
        r = '0;
        for (int l = 0; l < 4; l++) begin
            v = $signed(w[l*16 +: 16]);
`ifdef LMS7_TX_BRST_ROUND_EN
            v = (v + 8) >>> 4;
            if (v > 2047) v = 2047;
`else
            v = v >>> 4;
`endif
            r[l*12 +: 12] = v[11:0];
        end
        return r;
    endfunction

    function automatic logic [63:0] gen(input int i);
        logic [63:0] w;
        logic [7:0] b;
        logic [1:0] ln;
        b = i[7:0];
        for (int l = 0; l < 4; l++) begin
            ln = l[1:0];
            w[l*16 +: 16] = {b, 2'b00, ln, 4'h0};
        end
        return w;
    endfunction

    // sample just before the edge, advance one cycle, drive after it
    task automatic tick();
        logic sh, mh;
        #4;
        sh = s_tvalid && s_tready;
        mh = m_tvalid && m_tready;
        if (burst_done) begin n_done++; done_ts = ts_now; end
        if (late) n_late++;
        if (underrun) n_und++;
        if (m_tvalid) begin
            n_mv++;
            if (!seen_mv) begin seen_mv = 1'b1; mv_ts = ts_now; end
            chk("sb_nonempty", 64'(mq.size() != 0), 64'd1);
            if (mq.size() != 0) chk("sb_data", m_tdata, mq[0]);
            if (mh) begin
                if (mq.size() != 0) void'(mq.pop_front());
                n_out++;
                outq.push_back(m_tdata);
            end
        end
        if (sh) begin
            n_cons++;
            if (!drop_mode) mq.push_back(red_m(s_tdata));
        end
        @(posedge mclk);
        #1;
        ts_now = ts_now + 32'd1;
        if (sh) sidx++;
        s_tdata = fix_mode ? fw[sidx % 2] : gen(sidx);
    endtask

    task automatic run_until_done(input string tag, input int budget);
        int d0;
        int k;
        d0 = n_done;
        k = 0;
        while (n_done == d0 && k < budget) begin
            tick();
            k++;
        end
        chk(tag, 64'(n_done - d0), 64'd1);
    endtask

    initial begin
        int c0, o0, l0, d0, u0, m0, c;
        rst_n = 1'b0; abort = 1'b0; cmd_valid = 1'b0;
        cmd_ts = '0; cmd_len = '0; ts_now = '0;
        s_tvalid = 1'b0; m_tready = 1'b0;
        drop_mode = 1'b0; fix_mode = 1'b0; seen_mv = 1'b0;
        mv_ts = '0; done_ts = '0;
        fw[0] = 64'h7FF0_8000_1234_FFFF;
        fw[1] = 64'h7FFF_7FF8_0008_FFF8;
        s_tdata = gen(0);
        #2;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_m_tvalid", m_tvalid, 0);
        chk("rst_s_tready", s_tready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_m_tdata", m_tdata, 0);
        chk("rst_flags", {burst_done, late, underrun}, 0);
        chk("rst_ucnt", underrun_cnt, 0);
        @(posedge mclk); #1;
        rst_n = 1'b1;

        // basic: start 100, 4 words
        ts_now = 32'd90; cmd_ts = 32'd100; cmd_len = 16'd4;
        cmd_valid = 1'b1; s_tvalid = 1'b1; m_tready = 1'b1;
        o0 = n_out;
        tick();
        cmd_valid = 1'b0;
        chk("basic_busy", busy, 1);
        run_until_done("basic_done", 40);
        chk("basic_first_ts", mv_ts, 101);
        chk("basic_done_ts", done_ts, 105);
        chk("basic_words", 64'(n_out - o0), 4);
        chk("basic_sb_empty", 64'(mq.size()), 0);
        chk("basic_ucnt", underrun_cnt, 0);

        // data map incl. saturation corner
        fix_mode = 1'b1; sidx = 0; s_tdata = fw[0];
        outq.delete();
        cmd_ts = ts_now + 32'd2; cmd_len = 16'd2; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        run_until_done("map_done", 20);
        chk("map_count", 64'(outq.size()), 2);
        chk("map_word0", outq[0], EXP0);
        chk("map_word1", outq[1], EXP1);
        fix_mode = 1'b0;

        // late: start already passed
        drop_mode = 1'b1;
        ts_now = 32'd60; cmd_ts = 32'd50; cmd_len = 16'd3;
        cmd_valid = 1'b1;
        c0 = n_cons; l0 = n_late; d0 = n_done; m0 = n_mv;
        tick();
        cmd_valid = 1'b0;
        repeat (10) tick();
        chk("late_pulse", 64'(n_late - l0), 1);
        chk("late_consumed", 64'(n_cons - c0), 3);
        chk("late_no_done", 64'(n_done - d0), 0);
        chk("late_no_mvalid", 64'(n_mv - m0), 0);
        chk("late_idle", busy, 0);
        drop_mode = 1'b0;

        // underrun: release every 2nd cycle, no data for 3 slots
        s_tvalid = 1'b0; m_tready = 1'b0;
        cmd_ts = ts_now + 32'd1; cmd_len = 16'd6; cmd_valid = 1'b1;
        u0 = n_und; o0 = n_out; d0 = n_done;
        tick();
        cmd_valid = 1'b0;
        tick();
        c = 0;
        while (n_done == d0 && c < 80) begin
            m_tready = (c % 2 == 0);
            s_tvalid = (c >= 5);
            tick();
            c++;
        end
        chk("und_done", 64'(n_done - d0), 1);
        chk("und_cnt", underrun_cnt, 3);
        chk("und_pulses", 64'(n_und - u0), 3);
        chk("und_words", 64'(n_out - o0), 6);
        chk("und_sb_empty", 64'(mq.size()), 0);

        // zero-length burst
        cmd_len = 16'd0; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        chk("zero_done", burst_done, 1);
        chk("zero_busy", busy, 0);
        chk("zero_ucnt_clr", underrun_cnt, 0);
        tick();
        chk("zero_done_pulse", burst_done, 0);
        chk("zero_busy2", busy, 0);

        // backpressure: m_tready low 5 cycles
        s_tvalid = 1'b1; m_tready = 1'b1;
        cmd_ts = ts_now + 32'd1; cmd_len = 16'd8; cmd_valid = 1'b1;
        o0 = n_out; c0 = n_cons; d0 = n_done;
        tick();
        cmd_valid = 1'b0;
        c = 0;
        while (n_done == d0 && c < 60) begin
            m_tready = !(c >= 3 && c < 8);
            tick();
            c++;
        end
        chk("bp_done", 64'(n_done - d0), 1);
        chk("bp_words", 64'(n_out - o0), 8);
        chk("bp_consumed", 64'(n_cons - c0), 8);
        chk("bp_sb_empty", 64'(mq.size()), 0);

        // abort after 2 of 8 words, with a competing command
        m_tready = 1'b1;
        cmd_ts = ts_now + 32'd1; cmd_len = 16'd8; cmd_valid = 1'b1;
        c0 = n_cons; d0 = n_done;
        tick();
        cmd_valid = 1'b0;
        c = 0;
        while (n_cons - c0 < 2 && c < 20) begin
            tick();
            c++;
        end
        chk("abort_pre_busy", busy, 1);
        abort = 1'b1; cmd_valid = 1'b1; cmd_len = 16'd5;
        #1;
        chk("abort_cmd_ready", cmd_ready, 0);
        chk("abort_s_tready", s_tready, 0);
        tick();
        abort = 1'b0; cmd_valid = 1'b0;
        chk("abort_idle", busy, 0);
        chk("abort_mvalid", m_tvalid, 0);
        chk("abort_consumed", 64'(n_cons - c0), 2);
        tick();
        chk("abort_no_accept", busy, 0);
        chk("abort_no_done", 64'(n_done - d0), 0);
        chk("abort_sb_empty", 64'(mq.size()), 0);

        // timestamp wrap
        ts_now = 32'hFFFF_FFFE; cmd_ts = 32'd2; cmd_len = 16'd2;
        cmd_valid = 1'b1; seen_mv = 1'b0; l0 = n_late;
        tick();
        cmd_valid = 1'b0;
        chk("wrap_wait_busy", busy, 1);
        run_until_done("wrap_done", 30);
        chk("wrap_first_ts", mv_ts, 3);
        chk("wrap_not_late", 64'(n_late - l0), 0);

        // async reset mid-burst
        cmd_ts = ts_now + 32'd1; cmd_len = 16'd8; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick(); tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_mvalid", m_tvalid, 0);
        chk("arst_mdata", m_tdata, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog");
    end

endmodule
